// File: rtl/rsa_key_finder_pkg.sv
// Shared types and constants for the RSA private-exponent finder:
// FSM state encoding, error codes and the default operand width.
package rsa_kf_pkg;

    localparam int RSA_KF_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CHK_EVEN = 3'd1,
        ST_FACTOR   = 3'd2,
        ST_DIV_WAIT = 3'd3,
        ST_PHI      = 3'd4,
        ST_INV      = 3'd5,
        ST_FIN      = 3'd6
    } rsa_kf_state_e;

    localparam logic [1:0] RSA_KF_OK      = 2'd0;
    localparam logic [1:0] RSA_KF_PRIME   = 2'd1;
    localparam logic [1:0] RSA_KF_NOINV   = 2'd2;
    localparam logic [1:0] RSA_KF_TIMEOUT = 2'd3;

endpackage

// File: rtl/rsa_key_finder_if.sv
// Job request / result bundle between a key consumer (master) and the
// finder (slave).
interface rsa_key_finder_if
    import rsa_kf_pkg::*;
#(
    parameter int W = RSA_KF_W
) ();

    logic         start;
    logic [W-1:0] n;
    logic [W-1:0] e;
    logic         busy;
    logic         done;
    logic [1:0]   err;
    logic [W-1:0] p;
    logic [W-1:0] q;
    logic [W-1:0] phi;
    logic [W-1:0] d;

    modport master (
        output start, n, e,
        input  busy, done, err, p, q, phi, d
    );

    modport slave (
        input  start, n, e,
        output busy, done, err, p, q, phi, d
    );

endinterface

// File: rtl/rsa_key_finder_div.sv
// Restoring sequential divider: one quotient bit per cycle, ack pulses
// exactly W cycles after go. A new go restarts any division in flight.
module seq_divider #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         go,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         ack,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);

    localparam int CNT_W = $clog2(W) + 1;

    logic [W-1:0]     rem_q;
    logic [W-1:0]     quo_q;
    logic [W-1:0]     dvs_q;
    logic [CNT_W-1:0] cnt_q;
    logic             active_q;
    logic             ack_q;

    logic [W-1:0] src_rem_s;
    logic [W-1:0] src_quo_s;
    logic [W-1:0] src_dvs_s;
    logic [W:0]   trial_s;
    logic         fits_s;
    logic [W-1:0] rem_d;
    logic [W-1:0] quo_d;

    // The go cycle already performs the first step, so W steps end on time.
    assign src_rem_s = go ? {W{1'b0}} : rem_q;
    assign src_quo_s = go ? dividend  : quo_q;
    assign src_dvs_s = go ? divisor   : dvs_q;
    assign trial_s   = {src_rem_s, src_quo_s[W-1]};
    assign fits_s    = (trial_s >= {1'b0, src_dvs_s});
    assign rem_d     = fits_s ? W'(trial_s - {1'b0, src_dvs_s}) : trial_s[W-1:0];
    assign quo_d     = {src_quo_s[W-2:0], fits_s};

    // Division step sequencer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q    <= {W{1'b0}};
            quo_q    <= {W{1'b0}};
            dvs_q    <= {W{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            active_q <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            if (go) begin
                rem_q    <= rem_d;
                quo_q    <= quo_d;
                dvs_q    <= divisor;
                cnt_q    <= CNT_W'(W - 1);
                active_q <= 1'b1;
            end else if (active_q) begin
                rem_q <= rem_d;
                quo_q <= quo_d;
                cnt_q <= cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    active_q <= 1'b0;
                    ack_q    <= 1'b1;
                end
            end
        end
    end

    assign ack       = ack_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/rsa_key_finder.sv
// RSA private-exponent finder: trial-division factoring of n, totient, then
// incremental search for d. Optional job timeout under RSA_KF_TIMEOUT_EN.
module rsa_key_finder
    import rsa_kf_pkg::*;
#(
    parameter int W          = RSA_KF_W,
    parameter int MAX_CYCLES = 2**20
) (
    input  logic              clk,
    input  logic              rst,
    rsa_key_finder_if.slave   bus
);

    rsa_kf_state_e state_q;
    logic [W-1:0]   n_q;
    logic [W-1:0]   e_q;
    logic [W-1:0]   c_q;
    logic [2*W-1:0] sq_q;
    logic [W-1:0]   r_q;
    logic           go_q;
    logic           busy_q;
    logic           done_q;
    logic [1:0]     err_q;
    logic [W-1:0]   p_q;
    logic [W-1:0]   q_q;
    logic [W-1:0]   phi_q;
    logic [W-1:0]   d_q;

`ifdef RSA_KF_TIMEOUT_EN
    localparam int CYC_W = $clog2(MAX_CYCLES) + 1;
    logic [CYC_W-1:0] cyc_q;
`endif

    logic           div_ack_s;
    logic [W-1:0]   div_quo_s;
    logic [W-1:0]   div_rem_s;
    logic [W-1:0]   phi_s;
    logic [W:0]     rsum_s;
    logic [W-1:0]   r_next_s;
    logic [W-1:0]   d_inc_s;
    logic [2*W-1:0] sq_next_s;

    seq_divider #(.W(W)) u_div (
        .clk       (clk),
        .rst       (rst),
        .go        (go_q),
        .dividend  (n_q),
        .divisor   (c_q),
        .ack       (div_ack_s),
        .quotient  (div_quo_s),
        .remainder (div_rem_s)
    );

    // phi < n, so the W-bit truncated product is exact.
    assign phi_s     = (p_q - W'(1)) * (q_q - W'(1));
    assign rsum_s    = {1'b0, r_q} + {1'b0, e_q};
    assign r_next_s  = (rsum_s >= {1'b0, phi_q}) ? W'(rsum_s - {1'b0, phi_q}) : rsum_s[W-1:0];
    assign d_inc_s   = d_q + W'(1);
    assign sq_next_s = sq_q + {{(W-2){1'b0}}, c_q, 2'b00} + (2*W)'(4);

    // Job sequencer with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            n_q     <= {W{1'b0}};
            e_q     <= {W{1'b0}};
            c_q     <= {W{1'b0}};
            sq_q    <= {(2*W){1'b0}};
            r_q     <= {W{1'b0}};
            go_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= RSA_KF_OK;
            p_q     <= {W{1'b0}};
            q_q     <= {W{1'b0}};
            phi_q   <= {W{1'b0}};
            d_q     <= {W{1'b0}};
`ifdef RSA_KF_TIMEOUT_EN
            cyc_q   <= {CYC_W{1'b0}};
`endif
        end else begin
            go_q   <= 1'b0;
            done_q <= 1'b0;
`ifdef RSA_KF_TIMEOUT_EN
            if (busy_q) begin
                cyc_q <= cyc_q + CYC_W'(1);
            end
`endif
            case (state_q)
                ST_IDLE: begin
                    busy_q <= bus.start;
                    if (bus.start) begin
                        n_q     <= bus.n;
                        e_q     <= bus.e;
                        err_q   <= RSA_KF_OK;
                        p_q     <= {W{1'b0}};
                        q_q     <= {W{1'b0}};
                        phi_q   <= {W{1'b0}};
                        d_q     <= {W{1'b0}};
                        state_q <= ST_CHK_EVEN;
`ifdef RSA_KF_TIMEOUT_EN
                        cyc_q   <= {CYC_W{1'b0}};
`endif
                    end
                end
                ST_CHK_EVEN: begin
                    if (n_q < W'(4)) begin
                        err_q   <= RSA_KF_PRIME;
                        state_q <= ST_FIN;
                    end else if (!n_q[0]) begin
                        p_q     <= W'(2);
                        q_q     <= n_q >> 1;
                        state_q <= ST_PHI;
                    end else begin
                        c_q     <= W'(3);
                        sq_q    <= (2*W)'(9);
                        state_q <= ST_FACTOR;
                    end
                end
                ST_FACTOR: begin
                    if (sq_q > {{W{1'b0}}, n_q}) begin
                        err_q   <= RSA_KF_PRIME;
                        state_q <= ST_FIN;
                    end else begin
                        go_q    <= 1'b1;
                        state_q <= ST_DIV_WAIT;
                    end
                end
                ST_DIV_WAIT: begin
                    // An ack coincident with our own go is a leftover from an aborted division.
                    if (div_ack_s && !go_q) begin
                        if (div_rem_s == {W{1'b0}}) begin
                            p_q     <= c_q;
                            q_q     <= div_quo_s;
                            state_q <= ST_PHI;
                        end else begin
                            sq_q    <= sq_next_s;
                            c_q     <= c_q + W'(2);
                            state_q <= ST_FACTOR;
                        end
                    end
                end
                ST_PHI: begin
                    phi_q <= phi_s;
                    if ((e_q < W'(2)) || (e_q >= phi_s)) begin
                        err_q   <= RSA_KF_NOINV;
                        state_q <= ST_FIN;
                    end else begin
                        d_q     <= W'(1);
                        r_q     <= e_q;
                        state_q <= ST_INV;
                    end
                end
                ST_INV: begin
                    if (r_q == W'(1)) begin
                        state_q <= ST_FIN;
                    end else if (d_inc_s == phi_q) begin
                        err_q   <= RSA_KF_NOINV;
                        d_q     <= {W{1'b0}};
                        state_q <= ST_FIN;
                    end else begin
                        d_q <= d_inc_s;
                        r_q <= r_next_s;
                    end
                end
                ST_FIN: begin
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
`ifdef RSA_KF_TIMEOUT_EN
            if (busy_q && (state_q != ST_IDLE) && (state_q != ST_FIN) &&
                (cyc_q >= CYC_W'(MAX_CYCLES - 1))) begin
                err_q   <= RSA_KF_TIMEOUT;
                d_q     <= {W{1'b0}};
                state_q <= ST_FIN;
            end
`endif
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.err  = err_q;
    assign bus.p    = p_q;
    assign bus.q    = q_q;
    assign bus.phi  = phi_q;
    assign bus.d    = d_q;

endmodule

// File: tb/tb_rsa_key_finder.sv
// Self-checking bench for rsa_key_finder: directed and random jobs against
// an arithmetic reference model, plus reset-abort and busy-start cases.
module tb_rsa_key_finder;

    localparam int W      = 16;
    localparam int BUDGET = 20000;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int unsigned cur_n;

    rsa_key_finder_if #(.W(W)) bus ();

    rsa_key_finder #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s (n=%0d): observed %0d expected %0d", tag, cur_n, obs, exp);
        end
    endtask

    // Reference: smallest factor by plain search, totient, brute-force inverse.
    task automatic model(input int unsigned nn, input int unsigned ee,
                         output int unsigned p, output int unsigned q,
                         output int unsigned phi, output int unsigned d,
                         output int unsigned er);
        int unsigned f;
        p = 0; q = 0; phi = 0; d = 0; er = 0; f = 0;
        if (nn < 4) begin
            er = 1;
            return;
        end
        for (int unsigned c = 2; c * c <= nn; c++) begin
            if (nn % c == 0) begin
                f = c;
                break;
            end
        end
        if (f == 0) begin
            er = 1;
            return;
        end
        p = f;
        q = nn / f;
        phi = (p - 1) * (q - 1);
        if (ee < 2 || ee >= phi) begin
            er = 2;
            return;
        end
        for (longint unsigned k = 1; k < phi; k++) begin
            if ((k * ee) % phi == 1) begin
                d = int'(k);
                return;
            end
        end
        er = 2;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
        check({tag, "_done"}, {31'd0, bus.done}, 32'd0);
        check({tag, "_err"},  {30'd0, bus.err},  32'd0);
        check({tag, "_p"},    {16'd0, bus.p},    32'd0);
        check({tag, "_q"},    {16'd0, bus.q},    32'd0);
        check({tag, "_phi"},  {16'd0, bus.phi},  32'd0);
        check({tag, "_d"},    {16'd0, bus.d},    32'd0);
    endtask

    task automatic run_job(input int unsigned nn, input int unsigned ee, input bit noise);
        int unsigned ep, eq, ephi, ed, eer, t, exp_lat;
        int lat;
        bit seen;
        cur_n = nn;
        model(nn, ee, ep, eq, ephi, ed, eer);
        bus.n = W'(nn);
        bus.e = W'(ee);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        lat = 0;
        seen = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) check("busy_on", {31'd0, bus.busy}, 32'd1);
            if (bus.done) begin
                seen = 1'b1;
            end else if (noise && (lat % 5 == 2)) begin
                bus.start = 1'b1;
                bus.n = W'($urandom);
                bus.e = W'($urandom);
            end else begin
                bus.start = 1'b0;
            end
        end while (!seen && lat < BUDGET);
        bus.start = 1'b0;
        check("done_seen", {31'd0, seen}, 32'd1);
        if (seen) begin
            check("busy_at_done", {31'd0, bus.busy}, 32'd1);
            check("err", {30'd0, bus.err}, eer);
            check("p",   {16'd0, bus.p},   ep);
            check("q",   {16'd0, bus.q},   eq);
            check("phi", {16'd0, bus.phi}, ephi);
            check("d",   {16'd0, bus.d},   ed);
            if (eer == 0) begin
                t = (ep == 2) ? 0 : ((ep - 3) / 2 + 1);
                exp_lat = 4 + t * (W + 2) + ed;
                check("latency", lat, exp_lat);
            end
        end
    endtask

    task automatic tail_idle();
        @(negedge clk);
        check("done_drop", {31'd0, bus.done}, 32'd0);
        check("busy_drop", {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        int unsigned rn, re;
        checks = 0;
        errors = 0;
        cur_n = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.n = '0;
        bus.e = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", {31'd0, bus.busy}, 32'd0);

        run_job(10573, 89, 1'b0);
        tail_idle();
        run_job(15, 3, 1'b0);
        tail_idle();
        run_job(14, 5, 1'b0);
        tail_idle();
        run_job(13, 5, 1'b0);
        run_job(35, 6, 1'b0);
        tail_idle();
        run_job(1147, 7, 1'b1);
        tail_idle();

        cur_n = 10573;
        bus.n = 16'd10573;
        bus.e = 16'd89;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (40) @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_busy", {31'd0, bus.busy}, 32'd0);
        run_job(10573, 89, 1'b0);
        tail_idle();

        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(0, 1) == 1) rn = $urandom_range(2, 45) * $urandom_range(2, 45);
            else rn = $urandom_range(0, 2000);
            re = $urandom_range(0, (rn > 0) ? rn : 1);
            run_job(rn, re, (i % 3) == 0);
            tail_idle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rsa_key_finder.md
# rsa_key_finder

Parametrised successor to the fixed-constant RSA private-exponent finder. Takes a run-time modulus `n` and public exponent `e` over a start/done handshake. It factors `n` by trial division using a shared sequential divider, then computes `phi = (p-1)(q-1)`, then finds `d` with `d*e ≡ 1 (mod phi)` by an incremental modular search. It sits in front of the decryption datapath and supplies its key.

## Interface
- `W`, 16: operand width of `n`, `e`, `p`, `q`, `phi`, `d`.
- `MAX_CYCLES`, 2**20: timeout limit per job (only used with `RSA_KF_TIMEOUT_EN`).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: job request; sampled only in IDLE.
- `n` in W: modulus; latched on accepted `start`.
- `e` in W: public exponent; latched on accepted `start`.
- `busy` out 1: high from the cycle after accepted `start` until the `done` cycle, inclusive.
- `done` out 1: one-cycle pulse at job end.
- `err` out 2: 0 ok, 1 `n` prime or `n<4`, 2 no inverse (`gcd(e,phi)≠1`, `e<2` or `e>=phi`), 3 timeout.
- `p` out W: smaller factor.
- `q` out W: larger factor.
- `phi` out W: totient.
- `d` out W: private exponent.

## Operation
- FSM states: IDLE, CHK_EVEN, FACTOR, DIV_WAIT, PHI, INV, FIN.
- **IDLE**
  - On `start`: latch `n`, `e`; clear results; go to CHK_EVEN.
- **CHK_EVEN**
  - `n<4` → err=1.
  - `n[0]==0` → `p=2`, `q=n>>1`, go to PHI.
  - Otherwise set `c=3`, `sq=9`, go to FACTOR.
- **FACTOR**
  - If `sq>n` → err=1.
  - Else issue `n/c` to the divider and go to DIV_WAIT.
- **DIV_WAIT**
  - On divider `ack`: if remainder is 0, `p=c`, `q=quotient`, go to PHI.
  - Otherwise `sq += 4c+4`, `c += 2`, back to FACTOR.
  - `sq` is held in 2W bits; no multiplier is used.
- **PHI**
  - `phi=(p-1)*(q-1)`, truncated to W bits. This is exact because `phi<n`.
  - If `e<2` or `e>=phi` → err=2.
  - Else `d=1`, `r=e`, go to INV.
- **INV**, one step per cycle:
  - If `r==1` → success.
  - Else `d+=1`, `r=r+e`, minus `phi` if `r+e>=phi`. The sum is computed in W+1 bits.
  - If `d` reaches `phi` → err=2.
- **FIN**: pulse `done`, return to IDLE.
- All error exits go through FIN.
- Results hold until the next accepted `start`.
- `p`, `q`, `phi` remain valid when err=2.
- `start` while busy is ignored, with no queueing.
- `rst` mid-job aborts immediately. All outputs and state go to 0, state to IDLE, and the divider is cleared.

## Timing
- Reset values: `busy=0`, `done=0`, `err=0`, `p=q=phi=d=0`.
- `start` at edge k → `busy=1` at k+1.
- Divider: `go` pulse, `ack` exactly W cycles later (restoring, one bit per cycle).
- Each trial-division test costs W+2 cycles.
- INV costs one cycle per candidate `d`.
- Even `n` with d=1 found: `done` is asserted at start+5.
- `done` and `busy` are high in the same cycle; `busy` drops the cycle after.
- `start` sampled in the cycle after `done` is accepted; back-to-back jobs are allowed.

## Configuration
- `RSA_KF_TIMEOUT_EN` defined:
  - A cycle counter starts at accepted `start`.
  - Reaching `MAX_CYCLES` while busy forces err=3 and FIN, with `d=0`.
- Undefined: no counter, and err=3 is never produced.

## Structure
- Package `rsa_kf_pkg`:
  - state enum.
  - error-code constants `RSA_KF_OK`, `RSA_KF_PRIME`, `RSA_KF_NOINV`, `RSA_KF_TIMEOUT`.
  - default `W`.
- One sub-module, `seq_divider #(W)`, with ports:
  - `clk`, `rst`, `go`, `dividend`, `divisor`, `ack`, `quotient`, `remainder`.
  - Restoring, multi-cycle; reused by FACTOR only.

## Test plan
- `n=10573`, `e=89` → `p=97`, `q=109`, `phi=10368`, `d=233`, err=0.
- `n=15`, `e=3` → `p=3`, `q=5`, `phi=8`, `d=3`.
- `n=14`, `e=5` → even path, `p=2`, `q=7`, `phi=6`, `d=5`, `done` at start+9.
- `n=13`, `e=5` → err=1, `p=q=d=0`.
- `n=35`, `e=6` → `phi=24`, err=2, `d=0`.
- Mid-job cases:
  - Assert `rst` mid-FACTOR on `n=10573` → all outputs 0 next cycle.
  - Subsequent `start` completes correctly.
  - `start` pulses while busy have no effect.
